// File: rtl/seq_multiplier_8bit.sv
// Sequential unsigned shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH product
// over WIDTH iteration cycles, with a start/busy/done handshake.
module seq_multiplier_8bit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;
  logic             last;

  // The carry lives in sum[WIDTH] and shifts straight into acc's MSB.
  assign sum  = {1'b0, acc} + {1'b0, (q[0] ? a_reg : '0)};
  assign last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state == CALC) && last;
      case (state)
        IDLE: if (start) begin
          a_reg <= multiplicand;
          q     <= multiplier;
          acc   <= '0;
          cnt   <= '0;
        end
        CALC: begin
          acc <= sum[WIDTH:1];
          q   <= {sum[0], q[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          // Product register loads with the final shifted value on entry to DONE.
          if (last) product <= {sum, q[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_8bit.sv
// Directed-vector bench for seq_multiplier_8bit: table of operand/product
// records, handshake corner sequences, and a randomized sweep against a*b.
module tb_seq_multiplier_8bit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  multiplicand, multiplier;
  logic        busy, done;
  logic [15:0] product;

  int n_vec = 0;
  int n_err = 0;

  seq_multiplier_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start, scramble operands afterwards, check full handshake timeline.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                        input string tag);
    start = 1'b1; multiplicand = a; multiplier = b;
    tick();
    start = 1'b0; multiplicand = ~a; multiplier = b ^ 8'h5A;
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("%s busy c%0d", tag, k), busy, 1'b1);
      chk($sformatf("%s done c%0d", tag, k), done, (k == 9));
      if (k == 9) chk({tag, " product"}, product, p);
      if (k < 9) tick();
    end
    tick();
    chk({tag, " busy c10"}, busy, 1'b0);
    chk({tag, " done c10"}, done, 1'b0);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] last_p;
    int          gap, wait_cyc;
    bit          got;

    tbl[0] = '{8'h0F, 8'h0F, 16'h00E1};
    tbl[1] = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[2] = '{8'hFF, 8'h01, 16'h00FF};
    tbl[3] = '{8'h80, 8'h02, 16'h0100};
    tbl[4] = '{8'h00, 8'h5A, 16'h0000};
    tbl[5] = '{8'h5A, 8'h00, 16'h0000};
    tbl[6] = '{8'h03, 8'h07, 16'h0015};
    tbl[7] = '{8'h12, 8'h34, 16'h03A8};
    tbl[8] = '{8'hAB, 8'hCD, 16'h88EF};
    tbl[9] = '{8'h01, 8'h80, 16'h0080};

    rst = 1'b1; start = 1'b0; multiplicand = 8'h00; multiplier = 8'h00;
    tick(); tick();
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset product", product, 16'h0000);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d product hold", i), product, tbl[i].p);
    end

    // start pulsed while busy is ignored; a held start is re-accepted in cycle 10
    start = 1'b1; multiplicand = 8'h12; multiplier = 8'h34;
    tick();
    start = 1'b0;
    for (int k = 1; k < 4; k++) tick();
    start = 1'b1; multiplicand = 8'h99; multiplier = 8'h99;
    for (int k = 4; k < 9; k++) tick();
    chk("hold done c9", done, 1'b1);
    chk("hold product c9", product, 16'h03A8);
    tick();
    chk("hold busy c10", busy, 1'b0);
    tick();
    start = 1'b0;
    chk("hold busy c11", busy, 1'b1);
    tick();
    chk("hold product stable", product, 16'h03A8);
    for (int k = 12; k < 19; k++) tick();
    chk("hold done c19", done, 1'b1);
    chk("hold product c19", product, 16'h5B71);
    tick();

    // Reset mid-CALC: no done, product cleared
    start = 1'b1; multiplicand = 8'hAB; multiplier = 8'hCD;
    tick();
    start = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", busy, 1'b0);
    chk("abort product", product, 16'h0000);
    got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) got = 1'b1;
      tick();
    end
    chk("abort no done", got, 1'b0);
    run_op(8'h03, 8'h07, 16'h0015, "post-abort");

    // Random sweep
    last_p = product;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        chk("rnd gap stable", product, last_p);
        tick();
      end
      start = 1'b1; multiplicand = ra; multiplier = rb;
      tick();
      start = 1'b0; multiplicand = 8'($urandom); multiplier = 8'($urandom);
      wait_cyc = 0;
      while (!done && wait_cyc < 12) begin
        if (product !== last_p) chk("rnd product stable", product, last_p);
        tick();
        wait_cyc++;
      end
      chk("rnd done latency", wait_cyc + 1, 9);
      chk($sformatf("rnd %0h*%0h", ra, rb), product, 16'(ra * rb));
      last_p = 16'(ra * rb);
      tick();
      chk("rnd single done", done, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
